// File: rtl/rv_loader_pkg.sv
// rv_loader_pkg: shared types and constants for the imem stream loader.
// The optional checksum stage is selected by LOADER_CSUM_EN in the top level.
package rv_loader_pkg;

  // Frame start byte used when the instantiation does not override MAGIC.
  localparam logic [7:0] DefaultMagic = 8'hA5;

  // Width of the LEN field carried in the frame header.
  localparam int unsigned LenW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StError
  } ldr_state_t;

  // True when a frame asks for more words than imem can hold.
  function automatic logic len_exceeds(input logic [LenW-1:0] len, input int unsigned addr_w);
    return 32'(len) > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack: packs four stream bytes (LSB first) into one 32-bit word.
// word/word_valid are combinational so the top level can register the write on the 4th byte.
module loader_word_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  // Byte counter and right-shifting assembly of the lower three bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (clear) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_data, shift_q[23:8]};
    end
  end

  // The 4th byte completes the word as its most significant byte.
  always_comb begin
    word       = {byte_data, shift_q};
    word_valid = byte_valid && (cnt_q == 2'd3);
  end

endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: receives a framed byte stream, writes the packed words into imem and
// holds the core in reset until the frame has loaded.
// Frame: MAGIC, LEN_LO, LEN_HI, 4*LEN data bytes, and a trailing XOR checksum byte only when
// LOADER_CSUM_EN is defined.
module imem_stream_loader
  import rv_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = DefaultMagic
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

`ifdef LOADER_CSUM_EN
  localparam ldr_state_t StAfterData = StCsum;
`else
  localparam ldr_state_t StAfterData = StDone;
`endif

  ldr_state_t        state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [LenW-1:0]   rem_q;
  logic [ADDR_W-1:0] idx_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_rst_n_q;
  logic              done_q;
  logic              err_q;
`ifdef LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  logic            xfer;
  logic            pack_valid;
  logic            pack_clear;
  logic [31:0]     word;
  logic            word_valid;
  logic            last_word;
  logic [LenW-1:0] len_full;

  // Handshake and packer control; a restart drops any coincident byte.
  always_comb begin
    s_ready    = (state_q != StDone) && (state_q != StError);
    xfer       = s_valid && s_ready && !restart;
    pack_valid = xfer && (state_q == StData);
    pack_clear = restart || (state_q != StData);
    len_full   = {s_data, len_lo_q};
    last_word  = word_valid && (rem_q == LenW'(1));
  end

  loader_word_pack u_word_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Frame sequencing; restart overrides every state.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (xfer && (s_data == MAGIC)) state_d = StLenLo;
        StLenLo: if (xfer) state_d = StLenHi;
        StLenHi: begin
          if (xfer) begin
            if (len_exceeds(len_full, ADDR_W)) state_d = StError;
            else if (len_full == '0)           state_d = StAfterData;
            else                               state_d = StData;
          end
        end
        StData:  if (last_word) state_d = StAfterData;
`ifdef LOADER_CSUM_EN
        StCsum:  if (xfer) state_d = (s_data == csum_q) ? StDone : StError;
`endif
        StDone:  state_d = StDone;
        StError: state_d = StError;
        default: state_d = StError;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Length/index counters, imem write register and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q     <= 8'd0;
      rem_q        <= '0;
      idx_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (restart) begin
      // imem_addr/imem_wdata keep their last values; only the write strobe is squashed.
      len_lo_q     <= 8'd0;
      rem_q        <= '0;
      idx_q        <= '0;
      imem_we_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= word_valid;
      if (word_valid) begin
        imem_addr_q  <= idx_q;
        imem_wdata_q <= word;
        idx_q        <= idx_q + ADDR_W'(1);
        rem_q        <= rem_q - LenW'(1);
      end
      if (xfer && (state_q == StLenLo)) len_lo_q <= s_data;
      if (xfer && (state_q == StLenHi)) rem_q <= len_full;
      if (state_d == StDone)  done_q <= 1'b1;
      if (state_d == StError) err_q <= 1'b1;
      // Released one cycle after DONE is entered so imem sees the final write first.
      core_rst_n_q <= (state_q == StDone);
    end
  end

`ifdef LOADER_CSUM_EN
  // Running XOR over LEN_LO, LEN_HI and every data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'd0;
    end else if (restart) begin
      csum_q <= 8'd0;
    end else if (xfer) begin
      if (state_q == StLenLo)                            csum_q <= s_data;
      else if ((state_q == StLenHi) || (state_q == StData)) csum_q <= csum_q ^ s_data;
    end
  end
`endif

  // Registered outputs.
  always_comb begin
    imem_we    = imem_we_q;
    imem_addr  = imem_addr_q;
    imem_wdata = imem_wdata_q;
    core_rst_n = core_rst_n_q;
    load_done  = done_q;
    load_err   = err_q;
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: directed tests for imem_stream_loader (ADDR_W=8, MAGIC=A5).
// Frames carry a checksum byte only when LOADER_CSUM_EN is defined.
module tb_imem_stream_loader;

  localparam int unsigned AddrW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             restart;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic             imem_we;
  logic [AddrW-1:0] imem_addr;
  logic [31:0]      imem_wdata;
  logic             core_rst_n;
  logic             load_done;
  logic             load_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]       tx[$];
  logic [AddrW-1:0] wa[$];
  logic [31:0]      wd[$];

  always #5 clk = ~clk;

  imem_stream_loader #(
    .ADDR_W (AddrW),
    .MAGIC  (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  // Record every imem write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  // Two-word program: imem[0]=00100013, imem[1]=00200093; XOR of len+data bytes = B2.
  task automatic build_prog();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
`ifdef LOADER_CSUM_EN
    tx.push_back(8'hB2);
`endif
  endtask

  // Send tx; with max_gap > 0, valid drops for a random number of cycles before each byte.
  task automatic send_tx(input int unsigned max_gap);
    foreach (tx[i]) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          @(negedge clk);
          s_data  = 8'($urandom);
          s_valid = 1'b0;
        end
      end
      @(negedge clk);
      s_data  = tx[i];
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic pulse_restart(input logic with_byte);
    @(negedge clk);
    restart = 1'b1;
    s_valid = with_byte;
    s_data  = 8'hA5;
    @(posedge clk);
    #1;
    restart = 1'b0;
    s_valid = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; restart = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    #23;
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    n_vec++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    n_vec++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_imem_addr: got %h want 00", imem_addr); end
    n_vec++; if (imem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_imem_wdata: got %h want 0", imem_wdata); end
    n_vec++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
    n_vec++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", load_done); end
    n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", load_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    wa.delete(); wd.delete();
    build_prog();
    send_tx(0);
    n_vec++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL basic_done_now: got %b want 1", load_done); end
    n_vec++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL basic_core_rst_early: got %b want 0", core_rst_n); end
    @(posedge clk); #1;
    n_vec++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL basic_core_rst_rise: got %b want 1", core_rst_n); end
    repeat (2) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 2", wa.size()); end
    n_vec++; if (wa[0] !== 8'h00) begin n_bad++; $display("FAIL basic_addr0: got %h want 00", wa[0]); end
    n_vec++; if (wd[0] !== 32'h00100013) begin n_bad++; $display("FAIL basic_data0: got %h want 00100013", wd[0]); end
    n_vec++; if (wa[1] !== 8'h01) begin n_bad++; $display("FAIL basic_addr1: got %h want 01", wa[1]); end
    n_vec++; if (wd[1] !== 32'h00200093) begin n_bad++; $display("FAIL basic_data1: got %h want 00200093", wd[1]); end
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_done: got %b want 0", s_ready); end
    n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", load_err); end
  endtask

  task automatic test_garbage();
    pulse_restart(1'b0);
    n_vec++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL garbage_done_cleared: got %b want 0", load_done); end
    n_vec++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL garbage_core_rst_cleared: got %b want 0", core_rst_n); end
    tx = '{8'h00, 8'hFF, 8'h12};
    send_tx(0);
    build_prog();
    send_tx(0);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 2) begin n_bad++; $display("FAIL garbage_nwrites: got %0d want 2", wa.size()); end
    n_vec++; if (wa[0] !== 8'h00) begin n_bad++; $display("FAIL garbage_addr0: got %h want 00", wa[0]); end
    n_vec++; if (wd[0] !== 32'h00100013) begin n_bad++; $display("FAIL garbage_data0: got %h want 00100013", wd[0]); end
    n_vec++; if (wd[1] !== 32'h00200093) begin n_bad++; $display("FAIL garbage_data1: got %h want 00200093", wd[1]); end
    n_vec++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL garbage_done: got %b want 1", load_done); end
    n_vec++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL garbage_core_rst: got %b want 1", core_rst_n); end
  endtask

  task automatic test_len_overflow();
    pulse_restart(1'b0);
    tx = '{8'hA5, 8'h01, 8'h01};
    send_tx(0);
    n_vec++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", load_err); end
    n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready: got %b want 0", s_ready); end
    tx = '{8'h13, 8'h00, 8'h10, 8'h00};
    send_tx(0);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 0) begin n_bad++; $display("FAIL ovf_nwrites: got %0d want 0", wa.size()); end
    n_vec++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL ovf_core_rst: got %b want 0", core_rst_n); end
    n_vec++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL ovf_done: got %b want 0", load_done); end
  endtask

  task automatic test_len_zero();
    pulse_restart(1'b0);
    tx = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CSUM_EN
    tx.push_back(8'h00);
`endif
    send_tx(0);
    n_vec++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", load_done); end
    repeat (3) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 0) begin n_bad++; $display("FAIL zero_nwrites: got %0d want 0", wa.size()); end
    n_vec++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL zero_core_rst: got %b want 1", core_rst_n); end
  endtask

  // LEN = 256 fills imem exactly; word i = {i,i,i,i}, so the data bytes XOR to zero.
  task automatic test_len_max();
    pulse_restart(1'b0);
    tx = '{8'hA5, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      repeat (4) tx.push_back(8'(i));
    end
`ifdef LOADER_CSUM_EN
    tx.push_back(8'h01);
`endif
    send_tx(0);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 256) begin n_bad++; $display("FAIL max_nwrites: got %0d want 256", wa.size()); end
    n_vec++; if (wa[255] !== 8'hFF) begin n_bad++; $display("FAIL max_last_addr: got %h want ff", wa[255]); end
    n_vec++; if (wd[255] !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL max_last_data: got %h want ffffffff", wd[255]); end
    n_vec++; if (wd[128] !== 32'h80808080) begin n_bad++; $display("FAIL max_mid_data: got %h want 80808080", wd[128]); end
    n_vec++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL max_done: got %b want 1", load_done); end
    n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL max_err: got %b want 0", load_err); end
  endtask

`ifdef LOADER_CSUM_EN
  task automatic test_bad_csum();
    pulse_restart(1'b0);
    build_prog();
    tx[tx.size()-1] = 8'hB3;
    send_tx(0);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL csum_err: got %b want 1", load_err); end
    n_vec++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL csum_done: got %b want 0", load_done); end
    n_vec++; if (wa.size() !== 2) begin n_bad++; $display("FAIL csum_nwrites: got %0d want 2", wa.size()); end
    n_vec++; if (wd[1] !== 32'h00200093) begin n_bad++; $display("FAIL csum_data1: got %h want 00200093", wd[1]); end
    n_vec++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL csum_core_rst: got %b want 0", core_rst_n); end
  endtask
`endif

  task automatic test_restart();
    pulse_restart(1'b0);
    tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93};
    send_tx(0);
    // The A5 offered with the restart must be dropped, otherwise the next A5 reads as LEN_LO.
    pulse_restart(1'b1);
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready: got %b want 1", s_ready); end
    n_vec++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL restart_err_cleared: got %b want 0", load_err); end
    build_prog();
    send_tx(0);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 2) begin n_bad++; $display("FAIL restart_nwrites: got %0d want 2", wa.size()); end
    n_vec++; if (wa[0] !== 8'h00) begin n_bad++; $display("FAIL restart_addr0: got %h want 00", wa[0]); end
    n_vec++; if (wd[0] !== 32'h00100013) begin n_bad++; $display("FAIL restart_data0: got %h want 00100013", wd[0]); end
    n_vec++; if (wa[1] !== 8'h01) begin n_bad++; $display("FAIL restart_addr1: got %h want 01", wa[1]); end
    n_vec++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %b want 1", load_done); end
  endtask

  task automatic test_async_reset();
    pulse_restart(1'b0);
    tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93};
    send_tx(0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL arst_addr: got %h want 00", imem_addr); end
    n_vec++; if (imem_wdata !== 32'h0) begin n_bad++; $display("FAIL arst_wdata: got %h want 0", imem_wdata); end
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    wa.delete(); wd.delete();
    build_prog();
    send_tx(0);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 2) begin n_bad++; $display("FAIL arst_nwrites: got %0d want 2", wa.size()); end
    n_vec++; if (wa[0] !== 8'h00) begin n_bad++; $display("FAIL arst_addr0: got %h want 00", wa[0]); end
    n_vec++; if (wd[0] !== 32'h00100013) begin n_bad++; $display("FAIL arst_data0: got %h want 00100013", wd[0]); end
    n_vec++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL arst_done: got %b want 1", load_done); end
  endtask

  task automatic test_random_valid();
    pulse_restart(1'b0);
    build_prog();
    send_tx(3);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (wa.size() !== 2) begin n_bad++; $display("FAIL rand_nwrites: got %0d want 2", wa.size()); end
    n_vec++; if (wa[0] !== 8'h00) begin n_bad++; $display("FAIL rand_addr0: got %h want 00", wa[0]); end
    n_vec++; if (wd[0] !== 32'h00100013) begin n_bad++; $display("FAIL rand_data0: got %h want 00100013", wd[0]); end
    n_vec++; if (wa[1] !== 8'h01) begin n_bad++; $display("FAIL rand_addr1: got %h want 01", wa[1]); end
    n_vec++; if (wd[1] !== 32'h00200093) begin n_bad++; $display("FAIL rand_data1: got %h want 00200093", wd[1]); end
    n_vec++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL rand_done: got %b want 1", load_done); end
    n_vec++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL rand_core_rst: got %b want 1", core_rst_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_len_overflow();
    test_len_zero();
    test_len_max();
`ifdef LOADER_CSUM_EN
    test_bad_csum();
`endif
    test_restart();
    test_async_reset();
    test_random_valid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
